// File: rtl/demux4_pkg.sv
// Shared definitions for the 1:4 stream demultiplexer.
package demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/demux_fifo.sv
// Per-channel FIFO: registered head, no flow-through, no full-bypass.
module demux_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the pre-pop count, so a full FIFO refuses even while draining.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux4_stream.sv
// Routes one valid/ready stream into four independently buffered output channels.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  sel_t                    in_sel,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic                    busy
);

    // Handshake: a beat moves on a rising edge where valid && ready; ready never looks at valid.
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    assign in_ready  = !full[in_sel];
    assign out_valid = ~empty;
    assign busy      = |out_valid;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign push[k] = in_valid && in_ready && (in_sel == sel_t'(k));
        assign pop[k]  = out_valid[k] && out_ready[k];

        demux_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (push[k]),
            .wr_data (in_data),
            .pop     (pop[k]),
            .full    (full[k]),
            .empty   (empty[k]),
            .head    (out_data[k*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: directed scenarios plus randomized traffic against per-channel queues.
module tb_demux4_stream;
    import demux4_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    sel_t                    in_sel;
    logic [W-1:0]            in_data;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;
    logic [NUM_CH*W-1:0]     out_data;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    // Expected contents of each channel, oldest first.
    logic [W-1:0] exp_q [NUM_CH][$];

    demux4_stream #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producer rule: an unaccepted beat stays put until accepted.
    logic   pend;
    sel_t   p_sel;
    logic [W-1:0] p_data;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                checks++;
                if (in_valid !== 1'b1 || in_sel !== p_sel || in_data !== p_data) begin
                    errors++;
                    $display("FAIL producer_hold: valid=%0b sel=%0d data=%h, held sel=%0d data=%h",
                             in_valid, in_sel, in_data, p_sel, p_data);
                end
            end
            pend   = in_valid && !in_ready;
            p_sel  = in_sel;
            p_data = in_data;
        end
    end

    task automatic drive(input logic v, input int s, input logic [W-1:0] d, input logic [NUM_CH-1:0] r);
        in_valid  = v;
        in_sel    = sel_t'(s);
        in_data   = d;
        out_ready = r;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 0, '0, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        for (int s = 0; s < NUM_CH; s++) begin
            in_sel = sel_t'(s);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready sel=%0d: got %b want 1", s, in_ready); end
        end
    endtask

    task automatic test_single_beat;
        @(negedge clk);
        drive(1'b1, 2, 32'hA5A5_0002, 4'b0000);
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_no_flowthrough: got %b want 0000", out_valid); end
        @(negedge clk);
        drive(1'b0, 0, '0, 4'b0100);
        #1;
        checks++;
        if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid: got %b want 0100", out_valid); end
        checks++;
        if (out_data[2*W +: W] !== 32'hA5A5_0002) begin errors++; $display("FAIL single_data: got %h want a5a50002", out_data[2*W +: W]); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_pop: got %b want 0000", out_valid); end
        out_ready = '0;
    endtask

    task automatic test_fill_full;
        @(negedge clk);
        drive(1'b1, 1, 32'h11, 4'b0000);
        @(negedge clk);
        drive(1'b1, 1, 32'h22, 4'b0000);
        @(negedge clk);
        drive(1'b0, 1, '0, 4'b0000);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_sel1: got %b want 0", in_ready); end
        in_sel = 2'd0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_sel0: got %b want 1", in_ready); end
        drive(1'b1, 0, 32'h33, 4'b0000);
        @(negedge clk);
        drive(1'b0, 0, '0, 4'b0011);
        #1;
        checks++;
        if (out_valid !== 4'b0011) begin errors++; $display("FAIL full_other_valid: got %b want 0011", out_valid); end
        checks++;
        if (out_data[0 +: W] !== 32'h33) begin errors++; $display("FAIL full_ch0_data: got %h want 33", out_data[0 +: W]); end
        checks++;
        if (out_data[W +: W] !== 32'h11) begin errors++; $display("FAIL drain_first: got %h want 11", out_data[W +: W]); end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 4'b0010) begin errors++; $display("FAIL drain_valid: got %b want 0010", out_valid); end
        checks++;
        if (out_data[W +: W] !== 32'h22) begin errors++; $display("FAIL drain_second: got %h want 22", out_data[W +: W]); end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL drain_empty: got %b want 0000", out_valid); end
        out_ready = '0;
    endtask

    task automatic test_full_pop;
        @(negedge clk);
        drive(1'b1, 3, 32'h30, 4'b0000);
        @(negedge clk);
        drive(1'b1, 3, 32'h31, 4'b0000);
        @(negedge clk);
        drive(1'b0, 3, '0, 4'b0000);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_full: got %b want 0", in_ready); end
        drive(1'b1, 3, 32'h32, 4'b1000);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_no_bypass: got %b want 0", in_ready); end
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_accept_next: got %b want 1", in_ready); end
        checks++;
        if (out_data[3*W +: W] !== 32'h31) begin errors++; $display("FAIL fullpop_head1: got %h want 31", out_data[3*W +: W]); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b1000 || out_data[3*W +: W] !== 32'h32) begin
            errors++; $display("FAIL fullpop_head2: got valid=%b data=%h want 1000/32", out_valid, out_data[3*W +: W]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL fullpop_empty: got %b want 0000", out_valid); end
        out_ready = '0;
    endtask

    task automatic test_streaming;
        int pops = 0;
        int low_ready = 0;
        for (int i = 0; i < 104; i++) begin
            @(negedge clk);
            if (i < 100) drive(1'b1, i % NUM_CH, W'(i), 4'b1111);
            else         drive(1'b0, 0, '0, 4'b1111);
            #1;
            if (i < 100 && in_ready !== 1'b1) low_ready++;
            for (int k = 0; k < NUM_CH; k++) begin
                if (out_valid[k]) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++; $display("FAIL stream_extra ch=%0d: got %h want none", k, out_data[k*W +: W]);
                    end else begin
                        if (out_data[k*W +: W] !== exp_q[k][0]) begin
                            errors++; $display("FAIL stream_order ch=%0d: got %h want %h", k, out_data[k*W +: W], exp_q[k][0]);
                        end
                        void'(exp_q[k].pop_front());
                    end
                    pops++;
                end
            end
            if (i < 100 && in_ready) exp_q[i % NUM_CH].push_back(W'(i));
        end
        checks++;
        if (low_ready !== 0) begin errors++; $display("FAIL stream_ready_low: got %0d cycles want 0", low_ready); end
        checks++;
        if (pops !== 100) begin errors++; $display("FAIL stream_pops: got %0d want 100", pops); end
        out_ready = '0;
    endtask

    task automatic test_random;
        logic hold = 1'b0;
        logic acc;
        logic exp_v;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = sel_t'($urandom_range(0, 3));
                in_data  = $urandom;
            end
            out_ready = (c >= 9980) ? 4'b0000 : 4'($urandom_range(0, 15));
            #1;
            for (int k = 0; k < NUM_CH; k++) begin
                exp_v = (exp_q[k].size() > 0);
                checks++;
                if (out_valid[k] !== exp_v) begin
                    errors++; $display("FAIL rand_valid c=%0d ch=%0d: got %b want %b", c, k, out_valid[k], exp_v);
                end
                if (exp_v) begin
                    checks++;
                    if (out_data[k*W +: W] !== exp_q[k][0]) begin
                        errors++; $display("FAIL rand_data c=%0d ch=%0d: got %h want %h", c, k, out_data[k*W +: W], exp_q[k][0]);
                    end
                end
            end
            checks++;
            if (in_ready !== (exp_q[in_sel].size() < DEPTH)) begin
                errors++; $display("FAIL rand_ready c=%0d sel=%0d: got %b want %b", c, in_sel, in_ready, exp_q[in_sel].size() < DEPTH);
            end
            checks++;
            if (busy !== (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() > 0)) begin
                errors++; $display("FAIL rand_busy c=%0d: got %b", c, busy);
            end
            acc = in_valid && (exp_q[in_sel].size() < DEPTH);
            for (int k = 0; k < NUM_CH; k++) begin
                if (out_ready[k] && exp_q[k].size() > 0) void'(exp_q[k].pop_front());
            end
            if (acc) exp_q[in_sel].push_back(in_data);
            hold = in_valid && !acc;
        end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive(1'b0, 0, '0, '0);
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL midreset_valid: got %b want 0000", out_valid); end
        checks++;
        if (busy !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL midreset_clear: busy=%b data=%h want 0/0", busy, out_data); end
        for (int k = 0; k < NUM_CH; k++) exp_q[k].delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < NUM_CH; s++) begin
            in_sel = sel_t'(s);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready sel=%0d: got %b want 1", s, in_ready); end
        end
        @(negedge clk);
        drive(1'b1, 1, 32'hBEEF, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0010 || out_data[W +: W] !== 32'hBEEF) begin
            errors++; $display("FAIL midreset_recover: got valid=%b data=%h want 0010/beef", out_valid, out_data[W +: W]);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_fill_full();
        test_full_pop();
        test_streaming();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
